// File: rtl/caliptra_prim_subreg_pkg.sv
// caliptra_prim_subreg_pkg: shared types and helpers for the subregister read-response block
package caliptra_prim_subreg_pkg;
  typedef enum logic {RdRespIdle, RdRespResp} rdresp_state_e;
  function automatic logic odd_parity(input logic [255:0] data);
    return ~^data;
  endfunction
endpackage

// File: rtl/caliptra_prim_subreg_rdresp.sv
// caliptra_prim_subreg_rdresp: one-cycle register read responder with read-clear pulses
// Optional response parity enabled by CALIPTRA_PRIM_SUBREG_RDRESP_PARITY_EN.
module caliptra_prim_subreg_rdresp
  import caliptra_prim_subreg_pkg::*;
#(
  parameter int NumRegs = 8,
  parameter int DW = 32,
  parameter logic [NumRegs-1:0] RcMask = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [7:0]            req_addr_i,
  input  logic [NumRegs*DW-1:0] reg_q_i,
  output logic [NumRegs-1:0]    rd_pulse_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DW-1:0]         rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  rsp_parity_o,
  output logic [7:0]            err_cnt_o
);
  localparam int AW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  rdresp_state_e state, state_next;
  logic acc, mapped, err_q;
  logic [AW-1:0] idx;
  logic [DW-1:0] rd_data, data_q, cap_data;
  logic [7:0] cnt_q;
  assign rsp_valid_o = state == RdRespResp;
  assign req_ready_o = rst_i || !rsp_valid_o || rsp_ready_i;
  assign acc = !rst_i && req_valid_i && req_ready_o;
  assign mapped = int'(req_addr_i) < NumRegs;
  assign idx = req_addr_i[AW-1:0];
  assign cap_data = mapped ? rd_data : '0;
  assign rsp_data_o = data_q;
  assign rsp_err_o = err_q;
  assign err_cnt_o = cnt_q;
  // Pulse and capture share the acceptance cycle, so the pre-clear value is returned.
  always_comb begin
    rd_data = '0;
    rd_pulse_o = '0;
    for (int i = 0; i < NumRegs; i++) begin
      rd_data = (idx == AW'(i)) ? reg_q_i[i*DW +: DW] : rd_data;
      rd_pulse_o[i] = acc && mapped && RcMask[i] && (idx == AW'(i));
    end
  end
  always_comb begin
    state_next = acc ? RdRespResp : (rsp_ready_i ? RdRespIdle : state);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RdRespIdle;
      data_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_next;
      if (acc) begin
        data_q <= cap_data;
        err_q <= !mapped;
        cnt_q <= cnt_q + {7'b0, !mapped && cnt_q != 8'hff};
      end
    end
  end
`ifdef CALIPTRA_PRIM_SUBREG_RDRESP_PARITY_EN
  logic par_q;
  assign rsp_parity_o = par_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) par_q <= 1'b0;
    else if (acc) par_q <= odd_parity(256'(cap_data));
  end
`else
  assign rsp_parity_o = 1'b0;
`endif
endmodule

// File: doc/caliptra_prim_subreg_rdresp.md
CALIPTRA_PRIM_SUBREG_RDRESP -- requirements
Module: caliptra_prim_subreg_rdresp

Interface
REQ-001 SHALL have parameter NumRegs, default 8: number of subregisters readable (1..256).
REQ-002 SHALL have parameter DW, default 32: subregister data width.
REQ-003 SHALL have parameter RcMask [NumRegs-1:0], default '0: bit i set means register i is read-clear (RC).
REQ-004 SHALL derive localparam AW = max(1, $clog2(NumRegs)).
REQ-005 clk_i  input  1  the single clock.
REQ-006 rst_i  input  1  reset, synchronous and active-high.
REQ-007 req_valid_i  input  1  read request valid.
REQ-008 req_ready_o  output  1  read request accepted when high with req_valid_i.
REQ-009 req_addr_i  input  8  register index.
REQ-010 reg_q_i  input  NumRegs*DW  flattened current subregister values; register i is at bits [i*DW +: DW].
REQ-011 rd_pulse_o  output  NumRegs  one-hot read pulse per register; drives the subregister we input for RC registers.
REQ-012 rsp_valid_o  output  1  response valid.
REQ-013 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-014 rsp_data_o  output  DW  read data.
REQ-015 rsp_err_o  output  1  the address was unmapped.
REQ-016 rsp_parity_o  output  1  odd parity over rsp_data_o (see Configuration).
REQ-017 err_cnt_o  output  8  saturating count of error responses.

Function
REQ-018 SHALL implement an FSM with states IDLE and RESP.
REQ-019 req_ready_o SHALL equal !rsp_valid_o || rsp_ready_i.
REQ-020 Acceptance SHALL be req_valid_i && req_ready_o.
REQ-021 On acceptance with req_addr_i < NumRegs, the block SHALL register rsp_data_o = reg_q_i[req_addr_i] and rsp_err_o = 0.
REQ-022 On acceptance with req_addr_i >= NumRegs, the block SHALL register rsp_data_o = 0 and rsp_err_o = 1, and increment err_cnt_o with saturation at 255.
REQ-023 Latency SHALL be one cycle: rsp_valid_o asserts in the cycle after acceptance, and the FSM enters RESP.
REQ-024 rd_pulse_o[addr] SHALL be combinationally high only in the acceptance cycle, only for a mapped addr, and only if RcMask[addr] is set; all other bits SHALL be 0.
REQ-025 Because the pulse and the data capture occur in the same cycle, returned data SHALL be the pre-clear value, and the subregister clears at the same edge.
REQ-026 While rsp_valid_o && !rsp_ready_i, rsp_data_o, rsp_err_o and rsp_parity_o SHALL be held stable, and no rd_pulse_o SHALL be issued.
REQ-027 In RESP, rsp_ready_i with no new request SHALL return the FSM to IDLE and deassert rsp_valid_o.
REQ-028 In RESP, rsp_ready_i together with req_valid_i SHALL accept the new request and remain in RESP, giving one response per cycle.
REQ-029 A back-to-back read of the same RC register SHALL return the cleared value on the second read.

Reset
REQ-030 While rst_i is high at a clock edge, the block SHALL enter IDLE and clear rsp_valid_o, rsp_data_o, rsp_err_o, rsp_parity_o and err_cnt_o to 0.
REQ-031 rd_pulse_o SHALL be 0 and req_ready_o SHALL be 1 while rst_i is high.
REQ-032 A pending response at reset SHALL be discarded without being re-issued.

Configuration
REQ-033 With CALIPTRA_PRIM_SUBREG_RDRESP_PARITY_EN defined, rsp_parity_o SHALL be registered with the data as ~^data (odd parity), and it SHALL be 1 for error responses.
REQ-034 Without CALIPTRA_PRIM_SUBREG_RDRESP_PARITY_EN, rsp_parity_o SHALL be tied to 0 and no parity logic SHALL be present.

Structure
REQ-035 The FSM typedef rdresp_state_e {RdRespIdle, RdRespResp} SHALL live in caliptra_prim_subreg_pkg.
REQ-036 The odd-parity function SHALL live in caliptra_prim_subreg_pkg.
REQ-037 The module SHALL be flat, with no sub-module; the natural consumer is caliptra_prim_subreg with SwAccessRC, whose we is driven by rd_pulse_o[i].

Verification
REQ-038 Scenario: NumRegs=4, reg2=0xDEADBEEF, request addr 2, rsp_ready_i=1 -> next cycle rsp_valid_o=1, data 0xDEADBEEF, err 0.
REQ-039 Scenario: request addr 9 with NumRegs=4 -> data 0, err 1, err_cnt_o=1; after 300 such requests err_cnt_o=255.
REQ-040 Scenario: RcMask=4'b0010, reg1=0x5 modelled by a real RC subreg, two back-to-back reads of addr 1 -> responses 0x5 then 0x0; rd_pulse_o=4'b0010 in both acceptance cycles.
REQ-041 Scenario: rsp_ready_i=0 for 5 cycles with req_valid_i=1 -> req_ready_o=0, data stable, rd_pulse_o=0 throughout; one response is delivered when rsp_ready_i rises.
REQ-042 Scenario: rst_i asserted while rsp_valid_o=1 -> next cycle rsp_valid_o=0, err_cnt_o=0, FSM in IDLE.
REQ-043 Scenario: with the macro defined, reg0=0x1 -> rsp_parity_o=0; reg0=0x3 -> rsp_parity_o=1; without the macro rsp_parity_o=0 always.
